// File: rtl/frame_lock_pkg.sv
// frame_lock_pkg: shared FSM state, relock counter width and frame geometry helpers
package frame_lock_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int RELOCK_W = 16;

    function automatic int frame_w(input int symbol_w, input int symbols);
        return symbol_w * symbols;
    endfunction

    function automatic int slip_w(input int symbol_w);
        return (symbol_w > 1) ? $clog2(symbol_w) : 1;
    endfunction

endpackage

// File: rtl/frame_popcount.sv
// frame_popcount: combinational ones count of a frame-wide error vector
module frame_popcount #(
    parameter int W    = 40,
    localparam int C_W = $clog2(W + 1)
) (
    input  logic [W-1:0]   data,
    output logic [C_W-1:0] count
);

    // Sum every set bit of the error vector
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) count = count + C_W'(data[i]);
    end

endmodule

// File: rtl/multi_mode_frame_lock_detector.sv
// multi_mode_frame_lock_detector: training-frame aligner with bit-slip search and N-good/M-bad lock hysteresis.
// Define ERR_STATS_EN to add locked-frame and error-bit totals (total_frames, total_error_bits).
module multi_mode_frame_lock_detector
    import frame_lock_pkg::*;
#(
    parameter int DLINE_W  = 8,
    parameter int SYMBOL_W = 10,
    parameter int SYMBOLS  = 4,
    parameter int CNT_W    = 20,
    localparam int FRAME_W = frame_w(SYMBOL_W, SYMBOLS),
    localparam int SLIP_W  = slip_w(SYMBOL_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                half_rate,
    input  logic [DLINE_W-1:0]  dline,
    input  logic [SYMBOL_W-1:0] correct_value,
    input  logic [CNT_W-1:0]    lock_th,
    input  logic [CNT_W-1:0]    unlock_th,
    input  logic                clear_stats,
    output logic                locked,
    output logic [SLIP_W-1:0]   start_point,
    output logic [FRAME_W-1:0]  data_frame,
    output logic                lock_lost,
    output logic [RELOCK_W-1:0] relock_count
`ifdef ERR_STATS_EN
    ,
    output logic [43:0]         total_frames,
    output logic [35:0]         total_error_bits
`endif
);

    localparam int HALF_W = DLINE_W / 2;

    state_t             state, next_state;
    logic [CNT_W-1:0]   run_cnt, bad_cnt;
    logic [CNT_W:0]     run_inc, bad_inc, lock_eff;
    logic [FRAME_W-1:0] rep, expected;
    logic [FRAME_W-1:0] rot [2**SLIP_W];
    logic [HALF_W-1:0]  odd;
    logic               match, lock_hit, lose;

    assign rep = {SYMBOLS{correct_value}};

    for (genvar g = 0; g < 2**SLIP_W; g++) begin : g_rot
        if (g == 0 || g >= SYMBOL_W) begin : g_id
            assign rot[g] = rep;
        end else begin : g_sh
            assign rot[g] = {rep[FRAME_W-1-g:0], rep[FRAME_W-1:FRAME_W-g]};
        end
    end

    assign expected = rot[start_point];
    assign match    = data_frame == expected;

    for (genvar g = 0; g < HALF_W; g++) begin : g_odd
        assign odd[g] = dline[2*g+1];
    end

    assign run_inc  = {1'b0, run_cnt} + 1'b1;
    assign bad_inc  = {1'b0, bad_cnt} + 1'b1;
    assign lock_eff = (lock_th == '0) ? (CNT_W+1)'(1) : {1'b0, lock_th};
    assign lock_hit = state == HUNT && tick && match && run_inc >= lock_eff;
    assign lose     = state == LOCKED && tick && !match && unlock_th != '0 && bad_inc >= {1'b0, unlock_th};

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= HUNT;
        else state <= next_state;

    // Lock on the Nth consecutive good tick, drop on the Mth consecutive bad tick
    always_comb begin
        next_state = state;
        if (lock_hit) next_state = LOCKED;
        else if (lose) next_state = HUNT;
    end

    // Lock status decode
    always_comb locked = state == LOCKED;

    // Slip search and good/bad run counters, advanced only on frame ticks
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            run_cnt     <= '0;
            bad_cnt     <= '0;
            start_point <= '0;
        end else if (tick) begin
            if (state == HUNT) begin
                bad_cnt <= '0;
                run_cnt <= (!match || lock_hit) ? '0 : (&run_cnt) ? run_cnt : run_inc[CNT_W-1:0];
                if (!match)
                    start_point <= (start_point == SLIP_W'(SYMBOL_W - 1)) ? '0 : start_point + 1'b1;
            end else begin
                run_cnt <= '0;
                bad_cnt <= (match || lose) ? '0 : (&bad_cnt) ? bad_cnt : bad_inc[CNT_W-1:0];
            end
        end

    // Sticky loss flag and saturating relock counter; a clear beats a same-cycle loss
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else if (clear_stats) begin
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else if (lose) begin
            lock_lost    <= 1'b1;
            relock_count <= (&relock_count) ? relock_count : relock_count + 1'b1;
        end

    // Deserialiser shift register: whole word at full rate, odd bits only at half rate
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) data_frame <= '0;
        else data_frame <= half_rate ? {data_frame[FRAME_W-HALF_W-1:0], odd}
                                     : {data_frame[FRAME_W-DLINE_W-1:0], dline};

`ifdef ERR_STATS_EN
    localparam int PC_W = $clog2(FRAME_W + 1);

    logic [PC_W-1:0] err_bits;
    logic [44:0]     tf_inc;
    logic [36:0]     teb_sum;

    frame_popcount #(.W(FRAME_W)) u_popcount (
        .data  (data_frame ^ expected),
        .count (err_bits)
    );

    assign tf_inc  = {1'b0, total_frames} + 1'b1;
    assign teb_sum = {1'b0, total_error_bits} + 37'(err_bits);

    // Saturating totals of frames and error bits seen on ticks while locked
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            total_frames     <= '0;
            total_error_bits <= '0;
        end else if (clear_stats) begin
            total_frames     <= '0;
            total_error_bits <= '0;
        end else if (tick && state == LOCKED) begin
            total_frames     <= tf_inc[44] ? '1 : tf_inc[43:0];
            total_error_bits <= teb_sum[36] ? '1 : teb_sum[35:0];
        end
`endif

endmodule

// File: tb/tb_multi_mode_frame_lock_detector.sv
// tb_multi_mode_frame_lock_detector: vector table, directed corner sequences and random frames against a reference model
module tb_multi_mode_frame_lock_detector;

    localparam int     CNT_MAX = (1 << 20) - 1;
    localparam longint TF_MAX  = (64'd1 << 44) - 1;
    localparam longint TEB_MAX = (64'd1 << 36) - 1;

    typedef struct {
        bit          hr;
        logic [9:0]  cv;
        int          slip;
        bit          zero;
        logic [19:0] lth;
        int          ticks;
        bit          e_locked;
        int          e_sp;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, half_rate = 1'b0, clear_stats = 1'b0;
    logic [7:0]  dline = '0;
    logic [9:0]  correct_value = '0;
    logic [19:0] lock_th = '0, unlock_th = '0;
    logic        locked, lock_lost;
    logic [3:0]  start_point;
    logic [39:0] data_frame;
    logic [15:0] relock_count;
`ifdef ERR_STATS_EN
    logic [43:0] total_frames;
    logic [35:0] total_error_bits;
`endif

    int errors = 0, checks = 0;
    bit dup = 1'b0;

    logic [39:0] m_frame;
    int          m_sp, m_run, m_bad, m_relock;
    bit          m_locked, m_lost;
    longint      m_tf, m_teb;

    always #5 clk = ~clk;

    multi_mode_frame_lock_detector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .half_rate     (half_rate),
        .dline         (dline),
        .correct_value (correct_value),
        .lock_th       (lock_th),
        .unlock_th     (unlock_th),
        .clear_stats   (clear_stats),
        .locked        (locked),
        .start_point   (start_point),
        .data_frame    (data_frame),
        .lock_lost     (lock_lost),
        .relock_count  (relock_count)
`ifdef ERR_STATS_EN
        ,
        .total_frames     (total_frames),
        .total_error_bits (total_error_bits)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] pattern(input logic [9:0] cv, input int sp);
        for (int j = 0; j < 40; j++) pattern[j] = cv[((j - sp) % 10 + 10) % 10];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_zero();
        m_frame = '0; m_sp = 0; m_run = 0; m_bad = 0; m_relock = 0;
        m_locked = 0; m_lost = 0; m_tf = 0; m_teb = 0;
    endtask

    task automatic model_step();
        logic [39:0] e;
        bit          hit;
        if (!rst_n) begin
            model_zero();
            return;
        end
        e   = pattern(correct_value, m_sp);
        hit = m_frame == e;
        if (tick && m_locked) begin
            if (m_tf < TF_MAX) m_tf++;
            m_teb = m_teb + $countones(m_frame ^ e);
            if (m_teb > TEB_MAX) m_teb = TEB_MAX;
            if (hit) m_bad = 0;
            else if (unlock_th != 0 && m_bad + 1 >= int'(unlock_th)) begin
                m_locked = 0; m_bad = 0; m_lost = 1;
                if (m_relock < 65535) m_relock++;
            end else if (m_bad < CNT_MAX) m_bad++;
        end else if (tick) begin
            if (!hit) begin
                m_run = 0;
                m_sp  = (m_sp + 1) % 10;
            end else if (m_run + 1 >= ((lock_th == 0) ? 1 : int'(lock_th))) begin
                m_locked = 1;
                m_run    = 0;
            end else if (m_run < CNT_MAX) m_run++;
        end
        if (clear_stats) begin
            m_lost = 0; m_relock = 0; m_tf = 0; m_teb = 0;
        end
        if (half_rate) for (int i = 7; i >= 1; i -= 2) m_frame = {m_frame[38:0], dline[i]};
        else for (int i = 7; i >= 0; i--) m_frame = {m_frame[38:0], dline[i]};
    endtask

    task automatic compare();
        check("model_locked", 64'(locked), 64'(m_locked));
        check("model_start_point", 64'(start_point), 64'(m_sp));
        check("model_data_frame", 64'(data_frame), 64'(m_frame));
        check("model_lock_lost", 64'(lock_lost), 64'(m_lost));
        check("model_relock_count", 64'(relock_count), 64'(m_relock));
`ifdef ERR_STATS_EN
        check("model_total_frames", 64'(total_frames), 64'(m_tf));
        check("model_total_error_bits", 64'(total_error_bits), 64'(m_teb));
`endif
    endtask

    task automatic cyc(input logic t, input logic [7:0] d, input logic clr);
        tick = t; dline = d; clear_stats = clr;
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic send_frame(input logic [39:0] f, input logic clr);
        logic [7:0] d;
        logic [3:0] b;
        if (half_rate) begin
            for (int i = 9; i >= 0; i--) begin
                b = f[4*i +: 4];
                d = 8'($urandom);
                d[7] = b[3]; d[5] = b[2]; d[3] = b[1]; d[1] = b[0];
                if (dup) begin
                    d[6] = b[3]; d[4] = b[2]; d[2] = b[1]; d[0] = b[0];
                end
                cyc(1'b0, d, 1'b0);
            end
        end else begin
            for (int i = 4; i >= 0; i--) cyc(1'b0, f[8*i +: 8], 1'b0);
        end
        cyc(1'b1, 8'($urandom), clr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t        vt[11];
        logic [39:0] p, fr;
        int          slip, r;

        vt[0]  = '{1'b0, 10'h17C, 3, 1'b0, 20'd5, 2,  1'b0, 2};
        vt[1]  = '{1'b0, 10'h17C, 3, 1'b0, 20'd5, 7,  1'b0, 3};
        vt[2]  = '{1'b0, 10'h17C, 3, 1'b0, 20'd5, 8,  1'b1, 3};
        vt[3]  = '{1'b1, 10'h17C, 3, 1'b0, 20'd5, 8,  1'b1, 3};
        vt[4]  = '{1'b0, 10'h17C, 9, 1'b0, 20'd1, 10, 1'b1, 9};
        vt[5]  = '{1'b0, 10'h17C, 9, 1'b0, 20'd0, 10, 1'b1, 9};
        vt[6]  = '{1'b0, 10'h17C, 0, 1'b0, 20'd1, 1,  1'b1, 0};
        vt[7]  = '{1'b0, 10'h17C, 0, 1'b0, 20'd3, 2,  1'b0, 0};
        vt[8]  = '{1'b0, 10'h17C, 0, 1'b1, 20'd5, 11, 1'b0, 1};
        vt[9]  = '{1'b1, 10'h17C, 7, 1'b0, 20'd2, 9,  1'b1, 7};
        vt[10] = '{1'b0, 10'h2A5, 4, 1'b0, 20'd5, 9,  1'b1, 4};

        model_zero();
        do_reset();
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_start_point", 64'(start_point), 64'd0);
        check("reset_data_frame", 64'(data_frame), 64'd0);
        check("reset_relock_count", 64'(relock_count), 64'd0);

        dup = 1'b1;
        for (int i = 0; i < 11; i++) begin
            half_rate = vt[i].hr; correct_value = vt[i].cv; lock_th = vt[i].lth; unlock_th = '0;
            do_reset();
            for (int k = 0; k < vt[i].ticks; k++)
                send_frame(vt[i].zero ? 40'h0 : pattern(vt[i].cv, vt[i].slip), 1'b0);
            check($sformatf("vec%0d_locked", i), 64'(locked), 64'(vt[i].e_locked));
            check($sformatf("vec%0d_start_point", i), 64'(start_point), 64'(vt[i].e_sp));
        end

        half_rate = 1'b0; correct_value = 10'h17C; lock_th = 20'd5; unlock_th = 20'd3;
        p = pattern(10'h17C, 3);
        do_reset();
        repeat (8) send_frame(p, 1'b0);
        check("unlock_initial_lock", 64'(locked), 64'd1);
        repeat (2) send_frame(p ^ 40'h1, 1'b0);
        send_frame(p, 1'b0);
        check("unlock_hold_after_2bad", 64'(locked), 64'd1);
        repeat (3) send_frame(p ^ 40'h1, 1'b0);
        check("unlock_locked", 64'(locked), 64'd0);
        check("unlock_lock_lost", 64'(lock_lost), 64'd1);
        check("unlock_relock_count", 64'(relock_count), 64'd1);
        check("unlock_start_point", 64'(start_point), 64'd3);
        repeat (4) send_frame(p, 1'b0);
        check("relock_after_4", 64'(locked), 64'd0);
        send_frame(p, 1'b0);
        check("relock_after_5", 64'(locked), 64'd1);
        check("relock_start_point", 64'(start_point), 64'd3);

        unlock_th = '0;
        repeat (100) send_frame(p ^ 40'hF0, 1'b0);
        check("sticky_locked", 64'(locked), 64'd1);
        check("sticky_relock_count", 64'(relock_count), 64'd1);

`ifdef ERR_STATS_EN
        cyc(1'b0, 8'h00, 1'b1);
        check("stats_clear_frames", 64'(total_frames), 64'd0);
        check("stats_clear_bits", 64'(total_error_bits), 64'd0);
        send_frame(p ^ 40'h80_0001_0001, 1'b0);
        check("stats_frames_plus1", 64'(total_frames), 64'd1);
        check("stats_bits_plus3", 64'(total_error_bits), 64'd3);
        cyc(1'b0, 8'h00, 1'b1);
        check("stats_reclear_frames", 64'(total_frames), 64'd0);
        check("stats_reclear_bits", 64'(total_error_bits), 64'd0);
`endif

        unlock_th = 20'd1;
        send_frame(p ^ 40'h1, 1'b1);
        check("clrwin_locked", 64'(locked), 64'd0);
        check("clrwin_lock_lost", 64'(lock_lost), 64'd0);
        check("clrwin_relock_count", 64'(relock_count), 64'd0);
        check("clrwin_start_point", 64'(start_point), 64'd3);

        do_reset();
        repeat (2) send_frame(p, 1'b0);
        check("async_pre_start_point", 64'(start_point), 64'd2);
        cyc(1'b0, p[39:32], 1'b0);
        cyc(1'b0, p[31:24], 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_locked", 64'(locked), 64'd0);
        check("async_start_point", 64'(start_point), 64'd0);
        check("async_data_frame", 64'(data_frame), 64'd0);
        check("async_lock_lost", 64'(lock_lost), 64'd0);
        model_zero();
        cyc(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        send_frame(p, 1'b0);
        check("async_rehunt_slip1", 64'(start_point), 64'd1);
        repeat (2) send_frame(p, 1'b0);
        check("async_rehunt_slip3", 64'(start_point), 64'd3);
        repeat (5) send_frame(p, 1'b0);
        check("async_relock", 64'(locked), 64'd1);

        dup = 1'b0;
        slip = 3;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(9) == 0) correct_value = 10'($urandom);
            if ($urandom_range(9) == 0) slip = $urandom_range(9);
            if ($urandom_range(4) == 0) begin
                lock_th   = 20'($urandom_range(4));
                unlock_th = 20'($urandom_range(3));
            end
            half_rate = $urandom_range(3) == 0;
            repeat ($urandom_range(2)) cyc(1'b0, 8'($urandom), 1'b0);
            r  = $urandom_range(9);
            fr = pattern(correct_value, slip);
            if (r >= 7) fr = fr ^ (40'd1 << $urandom_range(39));
            if (r == 9) fr = {8'($urandom), 32'($urandom)};
            send_frame(fr, $urandom_range(19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
